cla_stream_ctrl: RTL and testbench

CLA_STREAM_CTRL -- requirements
Module: cla_stream_ctrl

---
 rtl/cla_pkg.sv | 22 ++
 rtl/cla_word_unpacker.sv | 24 ++
 rtl/cla_stream_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_cla_stream_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the streaming carry-lookahead adder controller:
// FSM state encoding and word-count / counter-width helpers.
package cla_pkg;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    SETTLE = 2'd2,
    UNLOAD = 2'd3
  } cla_state_e;

  // Number of stream words per adder operand.
  function automatic int unsigned cla_nw(input int unsigned nbit, input int unsigned wbit);
    return nbit / wbit;
  endfunction

  // Word counter width: wide enough to hold NW without wrapping.
  function automatic int unsigned cla_cnt_w(input int unsigned nw);
    return $clog2(nw + 1);
  endfunction

endpackage

// File: rtl/cla_word_unpacker.sv
// Selects one WBIT-wide word from the captured NBIT sum by word index.
// Indices at or beyond NW yield zero.
module cla_word_unpacker #(
  parameter int unsigned NBIT = 1024,
  parameter int unsigned WBIT = 32,
  parameter int unsigned NW   = 32,
  parameter int unsigned CW   = 6
) (
  input  logic [NBIT-1:0] data_i,
  input  logic [CW-1:0]   idx_i,
  output logic [WBIT-1:0] word_o
);

  // Word multiplexer over the captured sum.
  always_comb begin
    word_o = '0;
    for (int unsigned k = 0; k < NW; k++) begin
      if (idx_i == CW'(k)) begin
        word_o = data_i[k*WBIT +: WBIT];
      end
    end
  end

endmodule

// File: rtl/cla_stream_ctrl.sv
// Streaming front end for a wide external combinational adder: loads A then
// B word-serially (LSW first), waits SETTLE_CYC cycles for carry
// propagation, captures the sum and streams it out word-serially.
// Optional build macro CLA_COUT_WORD_EN appends a carry-out word.
module cla_stream_ctrl
  import cla_pkg::*;
#(
  parameter int unsigned NBIT       = 1024,
  parameter int unsigned WBIT       = 32,
  parameter int unsigned SETTLE_CYC = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WBIT-1:0] in_data,
  input  logic            in_cin,
  output logic [NBIT-1:0] add_a,
  output logic [NBIT-1:0] add_b,
  output logic            add_cin,
  input  logic [NBIT-1:0] add_s,
  input  logic            add_cout,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WBIT-1:0] out_data,
  output logic            out_last,
  output logic            busy
);

  localparam int unsigned NW  = cla_nw(NBIT, WBIT);
  localparam int unsigned CW  = cla_cnt_w(NW);
  localparam int unsigned SCW = $clog2(SETTLE_CYC + 1);
`ifdef CLA_COUT_WORD_EN
  localparam int unsigned NOUT = NW + 1;
`else
  localparam int unsigned NOUT = NW;
`endif

  cla_state_e      state_q, state_d;
  logic [CW-1:0]   wcnt_q, wcnt_d;
  logic [SCW-1:0]  scnt_q, scnt_d;
  logic [NBIT-1:0] a_q, b_q, sum_q;
  logic            cin_q;
  logic            capture;
  logic            in_xfer, out_xfer;
  logic [WBIT-1:0] sum_word;

`ifdef CLA_COUT_WORD_EN
  logic            cout_q;
`else
  logic            unused_cout;
  assign unused_cout = add_cout;
`endif

  assign in_ready  = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign out_valid = (state_q == UNLOAD);
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign out_last  = out_valid && (wcnt_q == CW'(NOUT - 1));
  assign busy      = !((state_q == LOAD_A) && (wcnt_q == '0));

  assign add_a   = a_q;
  assign add_b   = b_q;
  assign add_cin = cin_q;

  cla_word_unpacker #(
    .NBIT (NBIT),
    .WBIT (WBIT),
    .NW   (NW),
    .CW   (CW)
  ) u_unpack (
    .data_i (sum_q),
    .idx_i  (wcnt_q),
    .word_o (sum_word)
  );

  // Output word: sum word, or the carry-out word at index NW when enabled.
  always_comb begin
    out_data = '0;
    if (out_valid) begin
`ifdef CLA_COUT_WORD_EN
      if (wcnt_q == CW'(NW)) begin
        out_data = {{(WBIT-1){1'b0}}, cout_q};
      end else begin
        out_data = sum_word;
      end
`else
      out_data = sum_word;
`endif
    end
  end

  // State, word counter and settle counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD_A;
      wcnt_q  <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      scnt_q  <= scnt_d;
    end
  end

  // Next-state logic: load A, load B, settle, unload.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    scnt_d  = scnt_q;
    capture = 1'b0;
    case (state_q)
      LOAD_A: begin
        if (in_xfer) begin
          if (wcnt_q == CW'(NW - 1)) begin
            state_d = LOAD_B;
            wcnt_d  = '0;
          end else begin
            wcnt_d = wcnt_q + CW'(1);
          end
        end
      end
      LOAD_B: begin
        if (in_xfer) begin
          if (wcnt_q == CW'(NW - 1)) begin
            state_d = SETTLE;
            wcnt_d  = '0;
            scnt_d  = '0;
          end else begin
            wcnt_d = wcnt_q + CW'(1);
          end
        end
      end
      SETTLE: begin
        if (scnt_q == SCW'(SETTLE_CYC - 1)) begin
          capture = 1'b1;
          state_d = UNLOAD;
          wcnt_d  = '0;
        end else begin
          scnt_d = scnt_q + SCW'(1);
        end
      end
      UNLOAD: begin
        if (out_xfer) begin
          if (out_last) begin
            state_d = LOAD_A;
            wcnt_d  = '0;
          end else begin
            wcnt_d = wcnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = LOAD_A;
        wcnt_d  = '0;
        scnt_d  = '0;
      end
    endcase
  end

  // Operand packing on input transfers and result capture after settling.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      cin_q <= 1'b0;
      sum_q <= '0;
`ifdef CLA_COUT_WORD_EN
      cout_q <= 1'b0;
`endif
    end else begin
      if (in_xfer && (state_q == LOAD_A)) begin
        for (int unsigned k = 0; k < NW; k++) begin
          if (wcnt_q == CW'(k)) begin
            a_q[k*WBIT +: WBIT] <= in_data;
          end
        end
        if (wcnt_q == '0) begin
          cin_q <= in_cin;
        end
      end
      if (in_xfer && (state_q == LOAD_B)) begin
        for (int unsigned k = 0; k < NW; k++) begin
          if (wcnt_q == CW'(k)) begin
            b_q[k*WBIT +: WBIT] <= in_data;
          end
        end
      end
      if (capture) begin
        sum_q <= add_s;
`ifdef CLA_COUT_WORD_EN
        cout_q <= add_cout;
`endif
      end
    end
  end

endmodule

// File: tb/tb_cla_stream_ctrl.sv
// Self-checking bench for cla_stream_ctrl (NBIT=64, WBIT=32, SETTLE_CYC=1)
// with a behavioural a+b+cin adder and a word-queue reference model.
module tb_cla_stream_ctrl;

  localparam int unsigned NBIT   = 64;
  localparam int unsigned WBIT   = 32;
  localparam int unsigned SETTLE = 1;
  localparam int unsigned NW     = NBIT / WBIT;
`ifdef CLA_COUT_WORD_EN
  localparam int unsigned NOUT = NW + 1;
`else
  localparam int unsigned NOUT = NW;
`endif

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [WBIT-1:0] in_data;
  logic            in_cin;
  logic [NBIT-1:0] add_a;
  logic [NBIT-1:0] add_b;
  logic            add_cin;
  logic [NBIT-1:0] add_s;
  logic            add_cout;
  logic            out_valid;
  logic            out_ready;
  logic [WBIT-1:0] out_data;
  logic            out_last;
  logic            busy;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  cla_stream_ctrl #(
    .NBIT       (NBIT),
    .WBIT       (WBIT),
    .SETTLE_CYC (SETTLE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_cin    (in_cin),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_s     (add_s),
    .add_cout  (add_cout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  // Behavioural wide adder standing in for the external CLA.
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{NBIT{1'b0}}, add_cin};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [WBIT-1:0] w, input logic c, input bit gap);
    int unsigned budget;
    if (gap) begin
      in_valid = 1'b0;
      step();
    end
    in_valid = 1'b1;
    in_data  = w;
    in_cin   = c;
    budget   = 0;
    while (!in_ready && budget < 50) begin
      step();
      budget++;
    end
    if (!in_ready) check("in_ready_timeout", {63'd0, in_ready}, 64'd1);
    step();
    in_valid = 1'b0;
    in_data  = $urandom;
    in_cin   = 1'($urandom);
  endtask

  // One full operation: load, settle, unload, compared against A+B+cin.
  task automatic run_op(input logic [NBIT-1:0] a, input logic [NBIT-1:0] b, input logic cin,
                        input bit gaps, input int unsigned stall_first,
                        input int unsigned stall_max, input bit chk_lat);
    logic [WBIT-1:0] q[$];
    logic [NBIT:0]   full;
    int unsigned     steps;
    int unsigned     stall;
    full = {1'b0, a} + {1'b0, b} + (NBIT+1)'(cin);
    for (int k = 0; k < int'(NOUT); k++) q.push_back(WBIT'(full >> (k * WBIT)));

    for (int k = 0; k < int'(NW); k++) send_word(a[k*WBIT +: WBIT], cin, gaps && ($urandom_range(0, 1) == 1));
    for (int k = 0; k < int'(NW); k++) send_word(b[k*WBIT +: WBIT], 1'($urandom), gaps && ($urandom_range(0, 1) == 1));

    check("settle_in_ready", {63'd0, in_ready}, 64'd0);
    check("settle_busy", {63'd0, busy}, 64'd1);
    check("operand_a", add_a, a);
    check("operand_b", add_b, b);
    check("operand_cin", {63'd0, add_cin}, {63'd0, cin});

    steps = 0;
    while (!out_valid && steps < 20) begin
      step();
      steps++;
    end
    if (chk_lat) check("latency", 64'(steps + 1), 64'(SETTLE + 1));
    else check("out_valid_seen", {63'd0, out_valid}, 64'd1);

    for (int j = 0; j < int'(NOUT); j++) begin
      stall = (j == 0) ? stall_first : ((stall_max > 0) ? $urandom_range(0, stall_max) : 0);
      out_ready = 1'b0;
      for (int s = 0; s < int'(stall); s++) begin
        check("stall_valid", {63'd0, out_valid}, 64'd1);
        check("stall_data", {32'd0, out_data}, {32'd0, q[j]});
        step();
      end
      check("out_valid", {63'd0, out_valid}, 64'd1);
      check("out_data", {32'd0, out_data}, {32'd0, q[j]});
      check("out_last", {63'd0, out_last}, {63'd0, (j == int'(NOUT) - 1)});
      check("unload_in_ready", {63'd0, in_ready}, 64'd0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    check("done_out_valid", {63'd0, out_valid}, 64'd0);
    check("done_in_ready", {63'd0, in_ready}, 64'd1);
    check("done_busy", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    logic [NBIT-1:0] ra, rb;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_cin    = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_last", {63'd0, out_last}, 64'd0);
    check("rst_out_data", {32'd0, out_data}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_add_a", add_a, 64'd0);
    check("rst_add_b", add_b, 64'd0);
    check("rst_add_cin", {63'd0, add_cin}, 64'd0);
    rst = 1'b0;
    step();

    // Full carry ripple across both words.
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 1'b0, 0, 0, 1'b1);
    // Carry-in plus minimum latency.
    run_op(64'h0000_0000_0000_0001, 64'h0000_0000_0000_0002, 1'b1, 1'b0, 0, 0, 1'b1);
    // Five-cycle output stall on the first word.
    run_op(64'h0000_0000_0000_0001, 64'h0000_0000_0000_0002, 1'b1, 1'b0, 5, 0, 1'b1);

    // Reset after three input words, held through an offered transfer.
    send_word(32'hDEAD_BEEF, 1'b1, 1'b0);
    send_word(32'h1234_5678, 1'b0, 1'b0);
    send_word(32'hCAFE_F00D, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'h5555_AAAA;
    rst      = 1'b1;
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_add_a", add_a, 64'd0);
    check("midrst_add_b", add_b, 64'd0);
    run_op(64'h0000_0003_8000_0000, 64'h0000_0004_8000_0000, 1'b0, 1'b0, 0, 0, 1'b1);

    // Back-to-back operations with gapped input.
    run_op(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b1, 0, 2, 1'b0);
    run_op(64'h8000_0000_FFFF_FFFF, 64'h8000_0000_0000_0001, 1'b0, 1'b1, 1, 2, 1'b0);

    // Randomized operations, some with saturated operands.
    for (int i = 0; i < 25; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) ra = '1;
      if ($urandom_range(0, 3) == 0) rb = {$urandom_range(0, 1) == 1 ? 32'hFFFF_FFFF : 32'h0, 32'hFFFF_FFFF};
      run_op(ra, rb, 1'($urandom), 1'($urandom), $urandom_range(0, 3), 3, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
